// File: rtl/pc_pdt_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_pdt_if
// Description : Fetch-side bundle between the PC/predictor, the instruction
//               ROM and the EX-stage branch resolution logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_pdt_if;
    logic        stall;
    logic [31:0] pc;
    logic        ce;
    logic [31:0] pdt_pc;
    logic [31:0] pdt_inst;
    logic        pdt_taken;
    logic [31:0] pdt_target;
    logic        ex_br_valid;
    logic [31:0] ex_br_pc;
    logic        ex_br_taken;
    logic        ex_mispredict;
    logic [31:0] ex_redirect_pc;
    logic [31:0] pdt_miss_cnt;

    // master: the fetch-address generator itself
    modport master (
        input  stall, pdt_pc, pdt_inst,
        input  ex_br_valid, ex_br_pc, ex_br_taken, ex_mispredict, ex_redirect_pc,
        output pc, ce, pdt_taken, pdt_target, pdt_miss_cnt
    );

    // slave: ROM / pipeline side
    modport slave (
        output stall, pdt_pc, pdt_inst,
        output ex_br_valid, ex_br_pc, ex_br_taken, ex_mispredict, ex_redirect_pc,
        input  pc, ce, pdt_taken, pdt_target, pdt_miss_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pc_pdt.sv
`default_nettype none
// ============================================================================
// Module      : pc_pdt
// Description : IF-stage fetch-address generator with a 2-bit-counter branch
//               history table and zero-latency next-PC prediction.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_pdt #(
    parameter int          BHT_IDX_W = 6,
    parameter logic [31:0] START_PC  = 32'h0000_0000
) (
    input  wire logic  clk,
    input  wire logic  rst,
    pc_pdt_if.master   bus
);

    localparam int c_bht_entries = 1 << BHT_IDX_W;

    localparam logic [5:0] c_op_regimm = 6'b000001;
    localparam logic [5:0] c_op_j      = 6'b000010;
    localparam logic [5:0] c_op_jal    = 6'b000011;
    localparam logic [5:0] c_op_beq    = 6'b000100;
    localparam logic [5:0] c_op_bne    = 6'b000101;
    localparam logic [5:0] c_op_blez   = 6'b000110;
    localparam logic [5:0] c_op_bgtz   = 6'b000111;

    logic [31:0]          r_pc;
    logic                 r_ce;
    logic [31:0]          r_miss_cnt;
    logic [1:0]           r_bht [c_bht_entries];

    logic [5:0]           w_op;
    logic [4:0]           w_rt;
    logic [15:0]          w_imm;
    logic                 w_is_cond;
    logic                 w_is_jump;
    logic [31:0]          w_seq_pc;
    logic [31:0]          w_br_target;
    logic [31:0]          w_j_target;
    logic [1:0]           w_rd_ctr;
    logic                 w_taken;
    logic [31:0]          w_target;
    logic [31:0]          w_pc_next;
    logic [BHT_IDX_W-1:0] w_rd_idx;
    logic [BHT_IDX_W-1:0] w_wr_idx;
    logic [1:0]           w_wr_old;
    logic [1:0]           w_wr_new;
    logic                 w_unused;

    // ------------------------------------------------------------------
    // Decode of the word the ROM is returning
    // ------------------------------------------------------------------
    assign w_op  = bus.pdt_inst[31:26];
    assign w_rt  = bus.pdt_inst[20:16];
    assign w_imm = bus.pdt_inst[15:0];

    always_comb begin
        w_is_cond = 1'b0;
        w_is_jump = 1'b0;
        case (w_op)
            c_op_beq, c_op_bne, c_op_blez, c_op_bgtz: w_is_cond = 1'b1;
            c_op_regimm: w_is_cond = (w_rt == 5'b00000) || (w_rt == 5'b00001);
            c_op_j, c_op_jal: w_is_jump = 1'b1;
            default: begin
                w_is_cond = 1'b0;
                w_is_jump = 1'b0;
            end
        endcase
    end

    assign w_seq_pc    = bus.pdt_pc + 32'd4;
    assign w_br_target = w_seq_pc + {{14{w_imm[15]}}, w_imm, 2'b00};
    assign w_j_target  = {w_seq_pc[31:28], bus.pdt_inst[25:0], 2'b00};

    // Prediction lookup uses the registered fetch PC, so it is known in the
    // same cycle the ROM word comes back.
    assign w_rd_idx = r_pc[BHT_IDX_W+1:2];
    assign w_rd_ctr = r_bht[w_rd_idx];

    assign w_taken  = r_ce && (w_is_jump || (w_is_cond && w_rd_ctr[1]));

    always_comb begin
        w_target = r_pc + 32'd4;
        if (w_taken) begin
            w_target = w_is_jump ? w_j_target : w_br_target;
        end
    end

    // ------------------------------------------------------------------
    // Next-PC selection; a redirect overrides a stall
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_next = w_target;
        if (!r_ce) begin
            w_pc_next = START_PC;
        end else if (bus.ex_mispredict) begin
            w_pc_next = bus.ex_redirect_pc;
        end else if (bus.stall) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= START_PC;
            r_ce <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            r_ce <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_miss_cnt <= 32'd0;
        end else if (bus.ex_mispredict) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // BHT training from EX; saturating 2-bit counters
    // ------------------------------------------------------------------
    assign w_wr_idx = bus.ex_br_pc[BHT_IDX_W+1:2];
    assign w_wr_old = r_bht[w_wr_idx];

    always_comb begin
        w_wr_new = w_wr_old;
        if (bus.ex_br_taken) begin
            if (w_wr_old != 2'b11) w_wr_new = w_wr_old + 2'b01;
        end else begin
            if (w_wr_old != 2'b00) w_wr_new = w_wr_old - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_bht_entries; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (bus.ex_br_valid) begin
            r_bht[w_wr_idx] <= w_wr_new;
        end
    end

    assign w_unused = ^{bus.ex_br_pc[31:BHT_IDX_W+2], bus.ex_br_pc[1:0]};

    assign bus.pc           = r_pc;
    assign bus.ce           = r_ce;
    assign bus.pdt_taken    = w_taken;
    assign bus.pdt_target   = w_target;
    assign bus.pdt_miss_cnt = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_pdt.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_pdt
// Description : Directed scoreboard bench for pc_pdt with a small model ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_pdt;

    typedef struct packed {
        logic [31:0] pc;
        logic        ce;
        logic        taken;
        logic [31:0] target;
        logic [31:0] miss;
    } exp_t;

    logic   clk;
    logic   rst;
    exp_t   exp_q [$];
    string  name_q [$];
    int     checks;
    int     errors;

    pc_pdt_if bus ();

    pc_pdt #(
        .BHT_IDX_W (6),
        .START_PC  (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0010: return 32'h0800_0040;  // j 0x100
            32'h0000_0020: return 32'h1000_0004;  // beq +4
            32'h0000_0040: return 32'h1400_FFFF;  // bne -1
            32'h0000_0204: return 32'h0C00_0100;  // jal 0x400
            32'h0000_0400: return 32'h0401_0002;  // bgez +2
            default:       return 32'h0000_0000;
        endcase
    endfunction

    assign bus.pdt_pc   = bus.pc;
    assign bus.pdt_inst = rom_word(bus.pc);

    task automatic expect_now(input string nm, input logic [31:0] pc, input logic ce,
                              input logic taken, input logic [31:0] target,
                              input logic [31:0] miss);
        exp_t e;
        e.pc = pc; e.ce = ce; e.taken = taken; e.target = target; e.miss = miss;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expectation is consumed per falling edge while pending
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (bus.pc !== e.pc || bus.ce !== e.ce || bus.pdt_taken !== e.taken ||
                bus.pdt_target !== e.target || bus.pdt_miss_cnt !== e.miss) begin
                errors++;
                $display("FAIL %s: got pc=%h ce=%b taken=%b target=%h miss=%0d, want pc=%h ce=%b taken=%b target=%h miss=%0d",
                         nm, bus.pc, bus.ce, bus.pdt_taken, bus.pdt_target, bus.pdt_miss_cnt,
                         e.pc, e.ce, e.taken, e.target, e.miss);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.stall = 1'b0;
        bus.ex_br_valid = 1'b0;
        bus.ex_br_pc = 32'h0;
        bus.ex_br_taken = 1'b0;
        bus.ex_mispredict = 1'b0;
        bus.ex_redirect_pc = 32'h0;

        // Reset held for three edges, then released
        tick(); expect_now("rst_a", 32'h0, 1'b0, 1'b0, 32'h4, 32'd0);
        tick(); expect_now("rst_b", 32'h0, 1'b0, 1'b0, 32'h4, 32'd0);
        tick(); rst = 1'b1;
        expect_now("rel_pre_edge", 32'h0, 1'b0, 1'b0, 32'h4, 32'd0);
        tick(); expect_now("ce_first", 32'h0, 1'b1, 1'b0, 32'h4, 32'd0);
        tick(); expect_now("pc_4", 32'h4, 1'b1, 1'b0, 32'h8, 32'd0);
        tick(); expect_now("pc_8", 32'h8, 1'b1, 1'b0, 32'hC, 32'd0);
        tick();
        tick(); expect_now("jump", 32'h10, 1'b1, 1'b1, 32'h100, 32'd0);
        tick(); expect_now("jump_dst", 32'h100, 1'b1, 1'b0, 32'h104, 32'd0);

        // Train index of 0x20 taken three times, then redirect there
        bus.ex_br_valid = 1'b1; bus.ex_br_taken = 1'b1; bus.ex_br_pc = 32'h20;
        repeat (3) tick();
        bus.ex_br_valid = 1'b0;
        bus.ex_mispredict = 1'b1; bus.ex_redirect_pc = 32'h20;
        tick();
        bus.ex_mispredict = 1'b0;
        expect_now("beq_taken", 32'h20, 1'b1, 1'b1, 32'h34, 32'd1);

        // Hold PC and walk the counter back down (3 -> 2 -> 1 -> 0)
        bus.stall = 1'b1;
        bus.ex_br_valid = 1'b1; bus.ex_br_taken = 1'b0; bus.ex_br_pc = 32'h20;
        tick(); expect_now("beq_nt1", 32'h20, 1'b1, 1'b1, 32'h34, 32'd1);
        tick(); expect_now("beq_nt2", 32'h20, 1'b1, 1'b0, 32'h24, 32'd1);
        tick(); expect_now("beq_nt3", 32'h20, 1'b1, 1'b0, 32'h24, 32'd1);

        // Saturate index of 0x40 with five taken, one not-taken leaves it at 2
        bus.ex_br_taken = 1'b1; bus.ex_br_pc = 32'h40;
        repeat (5) tick();
        bus.ex_br_taken = 1'b0;
        tick();
        bus.ex_br_valid = 1'b0;
        bus.ex_mispredict = 1'b1; bus.ex_redirect_pc = 32'h40;
        tick();
        bus.ex_mispredict = 1'b0; bus.stall = 1'b0;
        expect_now("bne_back", 32'h40, 1'b1, 1'b1, 32'h40, 32'd2);
        tick(); expect_now("bne_loop", 32'h40, 1'b1, 1'b1, 32'h40, 32'd2);

        // Redirect wins over stall, then stall alone holds for four edges
        bus.stall = 1'b1;
        bus.ex_mispredict = 1'b1; bus.ex_redirect_pc = 32'h200;
        tick();
        bus.ex_mispredict = 1'b0;
        expect_now("redir_prio", 32'h200, 1'b1, 1'b0, 32'h204, 32'd3);
        for (int i = 0; i < 4; i++) begin
            tick(); expect_now("stall_hold", 32'h200, 1'b1, 1'b0, 32'h204, 32'd3);
        end
        bus.stall = 1'b0;
        tick(); expect_now("jal", 32'h204, 1'b1, 1'b1, 32'h400, 32'd3);
        tick(); expect_now("regimm_weak", 32'h400, 1'b1, 1'b0, 32'h404, 32'd3);

        // Asynchronous reset in the middle of a cycle at pc 0x88
        bus.ex_mispredict = 1'b1; bus.ex_redirect_pc = 32'h88;
        tick();
        bus.ex_mispredict = 1'b0;
        expect_now("pre_reset", 32'h88, 1'b1, 1'b0, 32'h8C, 32'd4);
        @(posedge clk);
        #2;
        rst = 1'b0;
        expect_now("async_rst", 32'h0, 1'b0, 1'b0, 32'h4, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        // BHT must be back to weakly not-taken
        bus.ex_mispredict = 1'b1; bus.ex_redirect_pc = 32'h40;
        tick();
        bus.ex_mispredict = 1'b0;
        expect_now("bht_cleared", 32'h40, 1'b1, 1'b0, 32'h44, 32'd1);
        tick();
        tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
